// File: rtl/lsu_req.sv
// rtl/lsu_req.sv - load/store request sequencer between execute stage and data memory
// One operation in flight: accept, optional memory request/response, then present writeback bus.
module lsu_req #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [2:0]                         in_ld_type,
  input  logic [1:0]                         in_st_type,
  input  logic [31:0]                        in_addr,
  input  logic [DATA_WIDTH-1:0]              in_wdata,
  input  logic                               in_regW,
  input  logic [ADDR_WIDTH-1:0]              in_regAddr,
  input  logic [DATA_WIDTH-1:0]              in_regData,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic                               mem_req_wen,
  output logic [31:0]                        mem_req_addr,
  output logic [31:0]                        mem_req_wdata,
  output logic [3:0]                         mem_req_wstrb,
  input  logic                               mem_resp_valid,
  input  logic [31:0]                        mem_resp_rdata,
  output logic                               mem_resp_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [2*DATA_WIDTH+ADDR_WIDTH+7:0] out_bus,
  output logic                               out_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [1:0]            state;
  logic [2:0]            ld_q;
  logic                  is_ld_q;
  logic                  is_st_q;
  logic                  mem_q;
  logic                  mis_q;
  logic [1:0]            sz_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  regw_q;
  logic [ADDR_WIDTH-1:0] rega_q;
  logic [DATA_WIDTH-1:0] regd_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic       in_is_ld;
  logic       in_is_st;
  logic [1:0] in_sz;
  logic       in_mis;

  // A load wins over a simultaneous store; reserved load codes decode as no load.
  always_comb begin
    in_is_ld = (in_ld_type >= 3'd1) && (in_ld_type <= 3'd5);
    in_is_st = !in_is_ld && (in_st_type != 2'd0);
    in_sz    = SZ_WORD;
    if (in_is_ld) begin
      case (in_ld_type)
        3'd1, 3'd4: in_sz = SZ_BYTE;
        3'd2, 3'd5: in_sz = SZ_HALF;
        default:    in_sz = SZ_WORD;
      endcase
    end else begin
      case (in_st_type)
        2'd1:    in_sz = SZ_BYTE;
        2'd2:    in_sz = SZ_HALF;
        default: in_sz = SZ_WORD;
      endcase
    end
    in_mis = (in_is_ld || in_is_st) &&
             (((in_sz == SZ_HALF) && in_addr[0]) ||
              ((in_sz == SZ_WORD) && (in_addr[1:0] != 2'b00)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ld_q    <= '0;
      is_ld_q <= 1'b0;
      is_st_q <= 1'b0;
      mem_q   <= 1'b0;
      mis_q   <= 1'b0;
      sz_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      regw_q  <= 1'b0;
      rega_q  <= '0;
      regd_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            ld_q    <= in_is_ld ? in_ld_type : 3'd0;
            is_ld_q <= in_is_ld;
            is_st_q <= in_is_st;
            mem_q   <= (in_is_ld || in_is_st) && !in_mis;
            mis_q   <= in_mis;
            sz_q    <= in_sz;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            regw_q  <= in_regW;
            rega_q  <= in_regAddr;
            regd_q  <= in_regData;
            rdata_q <= '0;
            state   <= ((in_is_ld || in_is_st) && !in_mis) ? S_REQ : S_DONE;
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_RESP;
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            if (is_ld_q) rdata_q <= mem_resp_rdata;
            state <= S_DONE;
          end
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  logic [3:0]  strobe;
  logic [31:0] wdata_rep;

  always_comb begin
    case (sz_q)
      SZ_BYTE: begin
        strobe    = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        strobe    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        strobe    = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  assign in_ready       = (state == S_IDLE);
  assign mem_req_valid  = (state == S_REQ);
  assign mem_resp_ready = (state == S_RESP);
  assign out_valid      = (state == S_DONE);
  assign out_misalign   = (state == S_DONE) && mis_q;

  assign mem_req_addr   = {addr_q[31:2], 2'b00};
  assign mem_req_wen    = is_st_q;
  assign mem_req_wstrb  = is_st_q ? strobe : 4'b0000;
  assign mem_req_wdata  = is_st_q ? wdata_rep : 32'd0;

  assign out_bus = {ld_q, regw_q, rega_q, regd_q, (mem_q ? strobe : 4'b0000), rdata_q};

endmodule

// File: doc/lsu_req.md
LSU_REQ -- requirements
Module: lsu_req

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; only 32 supported.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1; in_ready  output  1  -- exe-side handshake, transfer when both high.
REQ-006 in_ld_type  input  3  load op: 0 none, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu.
REQ-007 in_st_type  input  2  store op: 0 none, 1 sb, 2 sh, 3 sw.
REQ-008 in_addr  input  32  byte address; in_wdata  input  DATA_WIDTH  store data, low-aligned.
REQ-009 in_regW  input  1; in_regAddr  input  ADDR_WIDTH; in_regData  input  DATA_WIDTH  writeback info.
REQ-010 mem_req_valid  output  1; mem_req_ready  input  1  memory request handshake.
REQ-011 mem_req_wen  output  1; mem_req_addr  output  32; mem_req_wdata  output  32; mem_req_wstrb  output  4.
REQ-012 mem_resp_valid  input  1; mem_resp_rdata  input  32; mem_resp_ready  output  1.
REQ-013 out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-014 out_bus  output  2*DATA_WIDTH+ADDR_WIDTH+8, MSB->LSB: {ld_type[2:0], regW, regAddr, regData, strb[3:0], load_data}.
REQ-015 out_misalign  output  1  current out_bus is a misaligned access, valid with out_valid.

Function
REQ-016 FSM states IDLE, REQ, RESP, DONE; exactly one active.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 IDLE + accept, ld_type=0 and st_type=0: latch inputs, go DONE (out_valid next cycle), no memory request.
REQ-019 IDLE + accept, aligned memory op: latch inputs, go REQ.
REQ-020 ld_type!=0 and st_type!=0 together SHALL be treated as the load; store ignored, wen=0.
REQ-021 Misaligned = halfword op with addr[0]=1, or word op with addr[1:0]!=0; go DONE directly, strb=0, load_data=0, out_misalign=1, no memory request.
REQ-022 REQ: mem_req_valid=1, fields held stable until mem_req_ready; on handshake go RESP.
REQ-023 mem_req_addr = {addr[31:2],2'b00}.
REQ-024 Strobe: byte = 4'b0001<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111.
REQ-025 Store: wen=1, wstrb=strobe, wdata = sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
REQ-026 Load: wen=0, wstrb=0, wdata=0.
REQ-027 RESP: mem_resp_ready=1; on mem_resp_valid latch rdata (loads) and go DONE; zero-cycle-latency response not supported (earliest RESP cycle).
REQ-028 mem_resp_ready=0 outside RESP; responses in other states SHALL be ignored.
REQ-029 Each request yields one response, stores included; store completion waits for its response.
REQ-030 DONE: out_valid=1, out_bus/out_misalign stable; on out_ready go IDLE.
REQ-031 out_bus.strb = strobe for loads and stores, 0 for non-memory/misaligned; load_data = latched rdata for loads, else 0.
REQ-032 out_bus.ld_type = latched ld_type (0 for stores); regW/regAddr/regData pass through unchanged.
REQ-033 Latency: non-memory accept at cycle N -> out_valid N+1; memory accept N, ready at N+1, resp at N+2 -> out_valid N+3.
REQ-034 Back-to-back: next in_ready one cycle after output handshake (one op in flight).

Reset
REQ-035 rst=0 at clock edge: state IDLE; in_ready=1 after release, out_valid=0, mem_req_valid=0, mem_resp_ready=0, out_misalign=0, latches cleared to 0.
REQ-036 Reset in REQ/RESP/DONE SHALL abandon the operation without output; late responses ignored.

Verification
REQ-037 lw addr 0x100, rdata 0xDEADBEEF, ready/resp immediate -> req_addr 0x100, wen 0; out_valid 3 cycles after accept, strb 4'hF, load_data 0xDEADBEEF.
REQ-038 sb addr 0x203, wdata 0x000000A5 -> req_addr 0x200, wstrb 4'h8, wdata 0xA5A5A5A5, wen 1; out strb 4'h8, ld_type 0.
REQ-039 lh addr 0x101 -> no mem_req_valid; out_valid next cycle, out_misalign 1, strb 0, load_data 0.
REQ-040 lbu addr 0x302, mem_req_ready low 3 cycles, resp 2 cycles later -> req fields stable throughout; out strb 4'h4.
REQ-041 Non-memory op regW 1, regAddr 5, regData 0x1234, out_ready low 2 cycles -> out_valid next cycle, bus held; in_ready 0 until handshake.
REQ-042 rst low during RESP, stale resp after release -> out_valid stays 0; next lw completes normally.
